// File: rtl/mrd_mem_wr_if.sv
// Bus bundle for the mixed-radix DFT write-back stage: frame control,
// 5-lane twiddled input group, and the per-bank write ports.
interface mrd_mem_wr_if #(
    parameter int wData = 30,
    parameter int wAddr = 8
);
    logic                        start;
    logic [2:0]                  cfg_lanes;
    logic [11:0]                 cfg_groups;
    logic                        in_val;
    logic [0:4][wData-1:0]       in_real;
    logic [0:4][wData-1:0]       in_imag;
    logic [0:4][2:0]             in_bank_index;
    logic [0:4][wAddr-1:0]       in_bank_addr;
    logic [0:4]                  wr_en;
    logic [0:4][wAddr-1:0]       wr_addr;
    logic [0:4][wData-1:0]       wr_real;
    logic [0:4][wData-1:0]       wr_imag;
    logic                        busy;
    logic                        done;
    logic                        conflict;

    // Producer side: twiddle stage plus sequencer, consumes bank writes.
    modport master (
        output start, cfg_lanes, cfg_groups, in_val, in_real, in_imag,
               in_bank_index, in_bank_addr,
        input  wr_en, wr_addr, wr_real, wr_imag, busy, done, conflict
    );

    // Write-back stage side.
    modport slave (
        input  start, cfg_lanes, cfg_groups, in_val, in_real, in_imag,
               in_bank_index, in_bank_addr,
        output wr_en, wr_addr, wr_real, wr_imag, busy, done, conflict
    );
endinterface

// File: rtl/mrd_mem_wr.sv
// Write-back stage of the mixed-radix DFT datapath. Re-aligns the early
// bank index/address to the late twiddled data through an ADDR_DLY-deep
// delay line, scatters active lanes onto five banks, counts groups per
// frame and raises a sticky flag on bank conflicts.
module mrd_mem_wr #(
    parameter int wData    = 30,
    parameter int wAddr    = 8,
    parameter int ADDR_DLY = 8
) (
    input logic          clk,
    input logic          rst_n,
    mrd_mem_wr_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef logic [0:4][2:0]       idx_vec_t;
    typedef logic [0:4][wAddr-1:0] addr_vec_t;

    idx_vec_t  tap_idx;
    addr_vec_t tap_addr;

    generate
        if (ADDR_DLY == 0) begin : g_no_dly
            assign tap_idx  = bus.in_bank_index;
            assign tap_addr = bus.in_bank_addr;
        end else begin : g_dly
            idx_vec_t  dly_idx_q  [ADDR_DLY];
            idx_vec_t  dly_idx_d  [ADDR_DLY];
            addr_vec_t dly_addr_q [ADDR_DLY];
            addr_vec_t dly_addr_d [ADDR_DLY];

            // Shift index/address one stage deeper every cycle, valid or not.
            always_comb begin
                dly_idx_d[0]  = bus.in_bank_index;
                dly_addr_d[0] = bus.in_bank_addr;
                for (int i = 1; i < ADDR_DLY; i++) begin
                    dly_idx_d[i]  = dly_idx_q[i-1];
                    dly_addr_d[i] = dly_addr_q[i-1];
                end
            end

            // Delay-line registers.
            // NOTE: this register chain is deliberately reset: a frame started
            // right after reset must see zero taps, not stale or X indices.
            always_ff @(posedge clk) begin
                for (int i = 0; i < ADDR_DLY; i++) begin
                    if (!rst_n) begin
                        dly_idx_q[i]  <= '0;
                        dly_addr_q[i] <= '0;
                    end else begin
                        dly_idx_q[i]  <= dly_idx_d[i];
                        dly_addr_q[i] <= dly_addr_d[i];
                    end
                end
            end

            assign tap_idx  = dly_idx_q[ADDR_DLY-1];
            assign tap_addr = dly_addr_q[ADDR_DLY-1];
        end
    endgenerate

    state_t                state_q, state_d;
    logic [11:0]           cnt_q, cnt_d;
    logic [2:0]            lanes_q, lanes_d;
    logic [11:0]           groups_q, groups_d;
    logic [0:4]            wr_en_q, wr_en_d;
    logic [0:4][wAddr-1:0] wr_addr_q, wr_addr_d;
    logic [0:4][wData-1:0] wr_real_q, wr_real_d;
    logic [0:4][wData-1:0] wr_imag_q, wr_imag_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  conflict_q, conflict_d;

    // Frame sequencing, lane-to-bank crossbar and conflict detection.
    always_comb begin
        logic [0:4] taken;
        logic [2:0] b;
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        lanes_d    = lanes_q;
        groups_d   = groups_q;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_real_d  = wr_real_q;
        wr_imag_d  = wr_imag_q;
        conflict_d = conflict_q;
        taken      = '0;
        b          = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lanes_d    = bus.cfg_lanes;
                    groups_d   = bus.cfg_groups;
                    cnt_d      = '0;
                    conflict_d = 1'b0;
                    state_d    = (bus.cfg_groups == 12'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.in_val) begin
                    // Lowest lane claims a bank first; later claimants lose.
                    for (int l = 0; l < 5; l++) begin
                        if (l < int'(lanes_q)) begin
                            b = tap_idx[l];
                            if (b > 3'd4 || taken[b]) begin
                                conflict_d = 1'b1;
                            end else begin
                                taken[b]     = 1'b1;
                                wr_en_d[b]   = 1'b1;
                                wr_addr_d[b] = tap_addr[l];
                                wr_real_d[b] = bus.in_real[l];
                                wr_imag_d[b] = bus.in_imag[l];
                            end
                        end
                    end
                    cnt_d = cnt_q + 12'd1;
                    if (cnt_q == groups_q - 12'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, configuration and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lanes_q    <= '0;
            groups_q   <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_real_q  <= '0;
            wr_imag_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lanes_q    <= lanes_d;
            groups_q   <= groups_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_real_q  <= wr_real_d;
            wr_imag_q  <= wr_imag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_real  = wr_real_q;
    assign bus.wr_imag  = wr_imag_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_mrd_mem_wr.sv
// Self-checking bench for mrd_mem_wr: randomized stimulus, a cycle-level
// reference model feeding an expected-output queue, and a monitor that
// compares every cycle on the falling edge.
module tb_mrd_mem_wr;
    localparam int WD = 30;
    localparam int WA = 8;
    localparam int D  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mrd_mem_wr_if #(.wData(WD), .wAddr(WA)) bus();

    mrd_mem_wr #(.wData(WD), .wAddr(WA), .ADDR_DLY(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [0:4]         en;
        logic [0:4][WA-1:0] addr;
        logic [0:4][WD-1:0] re;
        logic [0:4][WD-1:0] im;
        logic               busy;
        logic               done;
        logic               conflict;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model ----------------
    // Frame bookkeeping: groups still owed, whether a frame is open, and
    // whether the one-cycle end marker is showing. Index/address history is
    // a queue of what was applied on previous clock edges (newest first).
    exp_t             cur;
    bit               in_frame;
    bit               end_now;
    int               remaining;
    int               m_lanes;
    logic [0:4][2:0]  hist_idx[$];
    logic [0:4][WA-1:0] hist_addr[$];

    always @(posedge clk) begin : model
        logic [0:4][2:0]    t_idx;
        logic [0:4][WA-1:0] t_addr;
        bit   [4:0]         used;
        int                 b;
        if (!rst_n) begin
            cur       = '0;
            in_frame  = 0;
            end_now   = 0;
            remaining = 0;
            m_lanes   = 0;
            hist_idx.delete();
            hist_addr.delete();
            repeat (D) begin
                hist_idx.push_back('0);
                hist_addr.push_back('0);
            end
        end else begin
            t_idx  = hist_idx[D-1];
            t_addr = hist_addr[D-1];
            hist_idx.push_front(bus.in_bank_index);
            hist_addr.push_front(bus.in_bank_addr);
            void'(hist_idx.pop_back());
            void'(hist_addr.pop_back());
            cur.en = '0;
            used   = '0;
            if (end_now) begin
                end_now = 0;
            end else if (!in_frame) begin
                if (bus.start) begin
                    m_lanes      = int'(bus.cfg_lanes);
                    remaining    = int'(bus.cfg_groups);
                    cur.conflict = 1'b0;
                    if (remaining == 0) end_now = 1;
                    else                in_frame = 1;
                end
            end else if (bus.in_val) begin
                for (int l = 0; l < 5; l++) begin
                    if (l < m_lanes) begin
                        b = int'(t_idx[l]);
                        if (b > 4 || used[b]) begin
                            cur.conflict = 1'b1;
                        end else begin
                            used[b]     = 1'b1;
                            cur.en[b]   = 1'b1;
                            cur.addr[b] = t_addr[l];
                            cur.re[b]   = bus.in_real[l];
                            cur.im[b]   = bus.in_imag[l];
                        end
                    end
                end
                remaining--;
                if (remaining == 0) begin
                    in_frame = 0;
                    end_now  = 1;
                end
            end
            cur.done = end_now;
            cur.busy = in_frame || end_now;
        end
        exp_q.push_back(cur);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("busy", 64'(bus.busy), 64'(e.busy));
            check("done", 64'(bus.done), 64'(e.done));
            check("conflict", 64'(bus.conflict), 64'(e.conflict));
            check("wr_en", 64'(bus.wr_en), 64'(e.en));
            for (int k = 0; k < 5; k++) begin
                check($sformatf("wr_addr[%0d]", k), 64'(bus.wr_addr[k]), 64'(e.addr[k]));
                check($sformatf("wr_real[%0d]", k), 64'(bus.wr_real[k]), 64'(e.re[k]));
                check($sformatf("wr_imag[%0d]", k), 64'(bus.wr_imag[k]), 64'(e.im[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    // mode 0: random index 0..7 and random address
    // mode 1: reversed index {4,3,2,1,0}, address tracks the cycle count
    // mode 2: radix-3 pattern {2,4,1,0,0}
    // mode 3: conflict pattern {0,2,4,2,3}
    int mode = 0;
    int cyc  = 0;
    int pat2[5] = '{2, 4, 1, 0, 0};
    int pat3[5] = '{0, 2, 4, 2, 3};

    task automatic step(input bit s, input bit v, input bit r = 1'b1);
        @(negedge clk);
        rst_n      = r;
        bus.start  = s;
        bus.in_val = v;
        cyc++;
        for (int l = 0; l < 5; l++) begin
            bus.in_real[l] = WD'($urandom);
            bus.in_imag[l] = WD'($urandom);
            case (mode)
                1:       bus.in_bank_index[l] = 3'(4 - l);
                2:       bus.in_bank_index[l] = 3'(pat2[l]);
                3:       bus.in_bank_index[l] = 3'(pat3[l]);
                default: bus.in_bank_index[l] = 3'($urandom_range(0, 7));
            endcase
            if (mode == 0) bus.in_bank_addr[l] = WA'($urandom);
            else           bus.in_bank_addr[l] = WA'(cyc * 5 + l);
        end
    endtask

    task automatic run_frame(input int lanes, input int groups, input int gap, input bit extra);
        bus.cfg_lanes  = 3'(lanes);
        bus.cfg_groups = 12'(groups);
        step(1'b1, 1'b0);
        // Scramble configuration after the start edge; the DUT must hold its latched copy.
        bus.cfg_lanes  = 3'($urandom_range(0, 7));
        bus.cfg_groups = 12'($urandom_range(0, 4095));
        for (int g = 0; g < groups; g++) begin
            step(1'b0, 1'b1);
            if (g != groups - 1) repeat (gap) step(extra, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0);
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.in_val        = 1'b0;
        bus.cfg_lanes     = '0;
        bus.cfg_groups    = '0;
        bus.in_real       = '0;
        bus.in_imag       = '0;
        bus.in_bank_index = '0;
        bus.in_bank_addr  = '0;

        // Reset held 3 cycles with random inputs.
        mode = 0;
        bus.cfg_lanes  = 3'd5;
        bus.cfg_groups = 12'd3;
        repeat (3) step(1'($urandom), 1'($urandom), 1'b0);

        // Frame immediately after release: taps still read the cleared delay line.
        run_frame(5, 2, 0, 1'b0);

        // Radix-5, reversed index, addresses tracking the cycle count.
        mode = 1;
        repeat (10) step(1'b0, 1'b0);
        run_frame(5, 4, 0, 1'b0);

        // Radix-3 with idle lanes 3-4 pointing at bank 0.
        mode = 2;
        repeat (10) step(1'b0, 1'b0);
        run_frame(3, 5, 1, 1'b0);

        // Conflict on bank 2, stays sticky through idle, clears on next start.
        mode = 3;
        repeat (10) step(1'b0, 1'b0);
        run_frame(5, 3, 0, 1'b0);
        mode = 1;
        repeat (10) step(1'b0, 1'b0);
        run_frame(5, 2, 0, 1'b0);

        // in_val in IDLE, 2-cycle gaps with stray starts, zero-group frame.
        repeat (4) step(1'b0, 1'b1);
        run_frame(4, 5, 2, 1'b1);
        run_frame(5, 0, 0, 1'b0);

        // Reset mid-frame after 2 of 6 groups, then a clean 6-group frame.
        bus.cfg_lanes  = 3'd5;
        bus.cfg_groups = 12'd6;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        run_frame(5, 6, 0, 1'b0);

        // Randomized frames.
        mode = 0;
        for (int f = 0; f < 12; f++) begin
            run_frame($urandom_range(2, 5), $urandom_range(1, 8),
                      $urandom_range(0, 2), 1'($urandom));
        end

        repeat (2) step(1'b0, 1'b0);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mrd_mem_wr.md
# mrd_mem_wr

Write-back stage of the mixed-radix DFT datapath. Consumes the 5-lane output of the radix-2/3/4/5 twiddle stage and scatters each lane into one of five dual-port data banks using that lane's bank index and bank address. It re-aligns the bank index and address, which arrive one registered cycle after the stage input, to the twiddled data, which arrives after the full DFT and twiddle latency. It also counts groups per frame and flags bank conflicts.

## Interface

Parameters
- wData, 30, width of each real/imag sample
- wAddr, 8, bank address width
- ADDR_DLY, 8, cycles between an index/address arriving and its matching `in_val`; legal range 0..15

Ports
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; arms a frame
- cfg_lanes  in  3  active lanes (radix), 2..5; sampled at `start`
- cfg_groups  in  12  groups per frame; sampled at `start`
- in_val  in  1  data group valid
- in_real, in_imag  in  [0:4][wData-1:0]  lane samples
- in_bank_index  in  [0:4][2:0]  target bank per lane; updated every cycle
- in_bank_addr  in  [0:4][wAddr-1:0]  target address per lane; updated every cycle
- wr_en  out  [0:4]  per-bank write enable
- wr_addr  out  [0:4][wAddr-1:0]  per-bank write address
- wr_real, wr_imag  out  [0:4][wData-1:0]  per-bank write data
- busy  out  1  frame in progress
- done  out  1  one-cycle end-of-frame pulse
- conflict  out  1  sticky error flag

## Operation

- Clock is `clk`. Reset is synchronous and active-low on `rst_n`. While `rst_n`=0, every output is 0, the FSM is in IDLE, the delay line is all-zero, and the group counter is 0.
- Delay line
  - `in_bank_index` and `in_bank_addr` are shifted into an ADDR_DLY-deep register chain every cycle, regardless of `in_val`.
  - The tap at depth ADDR_DLY is paired with the current `in_val` and data.
  - When ADDR_DLY=0, the tap is the live input.
- Lanes and crossbar
  - Lane l is active when l < cfg_lanes (value latched at `start`).
  - For each active lane with index b ≤ 4: set wr_en[b]=1, wr_addr[b]=addr[l], wr_real[b]/wr_imag[b]=lane l data.
  - Data passes through bit-exact, with no rounding or scaling.
  - Lanes ≥ cfg_lanes are ignored.
  - Banks not targeted in a cycle get wr_en=0. Their wr_addr/wr_data hold their previous value.
- Conflicts
  - If two or more active lanes target the same bank, the lowest-numbered lane wins and `conflict` is set.
  - An active lane with index > 4 writes nothing and sets `conflict`.
  - `conflict` stays set until the next accepted `start` or reset.
- FSM: IDLE, RUN, DONE
  - IDLE: when `start`=1, latch the configuration, clear the counter and `conflict`, and go to RUN. If cfg_groups=0, go to DONE instead.
  - RUN: each `in_val` cycle writes one group and increments the counter. On the `in_val` for which counter == cfg_groups−1, go to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
  - `in_val` outside RUN produces no writes and does not count.
  - `start` outside IDLE is ignored.
- Counter width is 12 bits. Terminal count is cfg_groups−1, so the counter never wraps.

## Timing

- Latency is 1 cycle. A group accepted at cycle t (RUN, `in_val`=1) appears on wr_en/wr_addr/wr_data at t+1. All outputs are registered.
- Alignment: the index/address applied at cycle t−ADDR_DLY is used for the data at cycle t.
- `busy` is registered and equals (state ≠ IDLE). It rises the cycle after `start` and falls the cycle after DONE.
- `done` is high for exactly the DONE cycle. For the last group accepted at t, the last wr_en and `done` are both high at t+1.
- Back-to-back `in_val` is supported at full rate. There is no backpressure, and the banks accept a write every cycle.
- `conflict` updates in the same cycle as the offending wr_en, i.e. t+1.
- If reset is asserted mid-frame, the frame is aborted: the next cycle has all outputs 0 and state IDLE, and no `done` is produced.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles with random inputs -> wr_en=0, busy=0, done=0, conflict=0 throughout; delay-line taps read 0 after release.
- Radix-5 frame, ADDR_DLY=8, cfg_groups=4, index {4,3,2,1,0}, addr=group number -> 4 writes, each at t+1. Bank 4 receives lane 0 and bank 0 receives lane 4. Addresses match the values applied 8 cycles before each `in_val`. `done` coincides with the 4th write. conflict=0.
- Radix-3, cfg_lanes=3, lanes 3–4 carrying index 0 -> only the banks chosen by lanes 0–2 are written; lanes 3–4 are ignored and conflict=0.
- Conflict: lanes 1 and 3 both index 2 -> bank 2 receives lane 1 data and conflict=1. conflict stays 1 after `done` and clears on the next `start`.
- Gaps and edges: `in_val` with 2-cycle gaps, `in_val` asserted in IDLE, `start` asserted during RUN, cfg_groups=0 -> no writes in IDLE; the extra `start` is ignored; the counter advances only on `in_val` in RUN; cfg_groups=0 gives `done` the cycle after `start` with no writes.
- Reset mid-frame after 2 of 6 groups -> no further writes, no `done`; a fresh `start` runs a complete 6-group frame correctly.
